// File: rtl/text_pkg.sv
// Shared constants for the 12x12 glyph text path: glyph geometry, font keys, and FSM states.
package text_pkg;

  localparam int unsigned GLYPH_W    = 12;
  localparam int unsigned GLYPH_H    = 12;
  localparam int unsigned GLYPH_BITS = 144;
  localparam int unsigned KEY_W      = 5;

  // Any key outside 0x00-0x0C makes the font ROM output all zeros.
  localparam logic [KEY_W-1:0] KEY_BLANK = 5'b11111;

  localparam logic [KEY_W-1:0] KEY_O    = 5'd0;
  localparam logic [KEY_W-1:0] KEY_H    = 5'd1;
  localparam logic [KEY_W-1:0] KEY_I    = 5'd2;
  localparam logic [KEY_W-1:0] KEY_G    = 5'd3;
  localparam logic [KEY_W-1:0] KEY_L    = 5'd4;
  localparam logic [KEY_W-1:0] KEY_E    = 5'd5;
  localparam logic [KEY_W-1:0] KEY_D    = 5'd6;
  localparam logic [KEY_W-1:0] KEY_N    = 5'd7;
  localparam logic [KEY_W-1:0] KEY_A    = 5'd8;
  localparam logic [KEY_W-1:0] KEY_R    = 5'd9;
  localparam logic [KEY_W-1:0] KEY_T    = 5'd10;
  localparam logic [KEY_W-1:0] KEY_UP   = 5'd11;
  localparam logic [KEY_W-1:0] KEY_DOWN = 5'd12;

  typedef enum logic {
    StIdle,
    StClear
  } state_e;

endpackage

// File: rtl/text_line_renderer.sv
// Writable line of font keys rendered into a fixed screen box; two-stage pixel pipeline
// with the font ROM sitting between the wordkey and glyph ports.
module text_line_renderer
  import text_pkg::*;
#(
  parameter logic [9:0]  ORIGIN_X  = 10'd100,
  parameter logic [9:0]  ORIGIN_Y  = 10'd50,
  parameter int unsigned NUM_CHARS = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  input  logic                         pix_valid_in,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_CHARS)-1:0] wr_addr,
  input  logic [KEY_W-1:0]             wr_key,
  input  logic                         clear,
  output logic                         busy,
  output logic [KEY_W-1:0]             wordkey,
  input  logic [GLYPH_BITS-1:0]        glyph,
  output logic                         pixel_on,
  output logic                         pix_valid_out
);

  localparam int unsigned SW = $clog2(NUM_CHARS);
  localparam logic [SW-1:0] LastIdx = SW'(NUM_CHARS - 1);
  localparam logic [10:0] XEnd = 11'(ORIGIN_X) + 11'(GLYPH_W * NUM_CHARS);
  localparam logic [10:0] YEnd = 11'(ORIGIN_Y) + 11'(GLYPH_H);

  state_e          state_q, state_d;
  logic [SW-1:0]   idx_q, idx_d;
  logic [KEY_W-1:0] buf_q [NUM_CHARS];
  logic            clr_we, user_we;

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state; a clear strobe while already clearing does not restart
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; clear wins over a write in the same cycle
  always_comb begin
    busy    = 1'b0;
    clr_we  = 1'b0;
    user_we = 1'b0;
    unique case (state_q)
      StIdle:  user_we = wr_en & ~clear;
      StClear: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) buf_q[i] <= KEY_BLANK;
    end else if (clr_we) begin
      buf_q[idx_q] <= KEY_BLANK;
    end else if (user_we) begin
      buf_q[wr_addr] <= wr_key;
    end
  end

  // Stage 1: box test happens on raw coordinates so the subtraction never wraps into the box
  logic       in_box;
  logic [9:0] dx, dy, slot_full, col_full;
  logic [SW-1:0] slot;
  logic [3:0] col, row;

  always_comb begin
    in_box = (DrawX >= ORIGIN_X) && ({1'b0, DrawX} < XEnd) &&
             (DrawY >= ORIGIN_Y) && ({1'b0, DrawY} < YEnd);
    dx        = DrawX - ORIGIN_X;
    dy        = DrawY - ORIGIN_Y;
    slot_full = dx / 10'd12;
    col_full  = dx % 10'd12;
    slot      = slot_full[SW-1:0];
    col       = col_full[3:0];
    row       = dy[3:0];
  end

  logic unused_bits;
  assign unused_bits = ^{slot_full[9:SW], col_full[9:4], dy[9:4]};

  logic [3:0] row_q, col_q;
  logic       in_box_q, valid_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wordkey  <= KEY_BLANK;
      row_q    <= '0;
      col_q    <= '0;
      in_box_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wordkey  <= in_box ? buf_q[slot] : KEY_BLANK;
      row_q    <= in_box ? row : 4'd0;
      col_q    <= in_box ? col : 4'd0;
      in_box_q <= in_box;
      valid_q  <= pix_valid_in;
    end
  end

  // Stage 2: glyph MSB is the top-left pixel
  logic [7:0] bit_idx;
  always_comb begin
    bit_idx = 8'(GLYPH_BITS - 1) - (8'(row_q) * 8'(GLYPH_W) + 8'(col_q));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_on      <= 1'b0;
      pix_valid_out <= 1'b0;
    end else begin
      pixel_on      <= in_box_q & valid_q & glyph[bit_idx];
      pix_valid_out <= valid_q;
    end
  end

endmodule

// File: tb/tb_text_line_renderer.sv
// Directed bench for text_line_renderer with a small behavioural font ROM for keys H and UP.
module tb_text_line_renderer;
  import text_pkg::*;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [9:0]   DrawX = '0;
  logic [9:0]   DrawY = '0;
  logic         pix_valid_in = 1'b0;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [4:0]   wr_key = '0;
  logic         clear = 1'b0;
  logic         busy;
  logic [4:0]   wordkey;
  logic [143:0] glyph;
  logic         pixel_on;
  logic         pix_valid_out;

  int checks = 0;
  int errors = 0;

  text_line_renderer #(
    .ORIGIN_X (10'd100),
    .ORIGIN_Y (10'd50),
    .NUM_CHARS(16)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .pix_valid_in (pix_valid_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_key       (wr_key),
    .clear        (clear),
    .busy         (busy),
    .wordkey      (wordkey),
    .glyph        (glyph),
    .pixel_on     (pixel_on),
    .pix_valid_out(pix_valid_out)
  );

  always #5 Clk = ~Clk;

  // H: vertical bars at cols 1-2 and 9-10 on rows 1-10, crossbar rows 5-6.
  // UP: shaft at cols 5-6 on every row.
  function automatic logic [143:0] font(input logic [4:0] key);
    logic [143:0] g;
    g = '0;
    if (key == KEY_H) begin
      for (int r = 1; r <= 10; r++) begin
        g[143 - (r * 12 + 1)]  = 1'b1;
        g[143 - (r * 12 + 2)]  = 1'b1;
        g[143 - (r * 12 + 9)]  = 1'b1;
        g[143 - (r * 12 + 10)] = 1'b1;
      end
      for (int c = 1; c <= 10; c++) begin
        g[143 - (5 * 12 + c)] = 1'b1;
        g[143 - (6 * 12 + c)] = 1'b1;
      end
    end else if (key == KEY_UP) begin
      for (int r = 0; r < 12; r++) begin
        g[143 - (r * 12 + 5)] = 1'b1;
        g[143 - (r * 12 + 6)] = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb glyph = font(wordkey);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [4:0] key);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_key  = key;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic exp);
    DrawX        = 10'(x);
    DrawY        = 10'(y);
    pix_valid_in = 1'b1;
    tick();
    pix_valid_in = 1'b0;
    tick();
    check({tag, "_valid"}, 32'(pix_valid_out), 32'd1);
    check(tag, 32'(pixel_on), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit, nvalid, cnt;

    tick();
    tick();
    Reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wordkey", 32'(wordkey), 32'h1f);
    check("rst_pixel_on", 32'(pixel_on), 32'd0);
    check("rst_pix_valid", 32'(pix_valid_out), 32'd0);

    // Sweep the whole box one pixel per cycle with a blank buffer
    lit = 0;
    nvalid = 0;
    for (int y = 50; y < 62; y++) begin
      for (int x = 100; x < 292; x++) begin
        DrawX = 10'(x);
        DrawY = 10'(y);
        pix_valid_in = 1'b1;
        tick();
        if (pix_valid_out) nvalid++;
        if (pixel_on) lit++;
      end
    end
    pix_valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (pix_valid_out) nvalid++;
      if (pixel_on) lit++;
    end
    check("sweep_lit", 32'(lit), 32'd0);
    check("sweep_count", 32'(nvalid), 32'd2304);
    check("sweep_busy", 32'(busy), 32'd0);

    wr(0, KEY_H);
    pix("h_101_51", 101, 51, 1'b1);
    pix("h_103_51", 103, 51, 1'b0);
    pix("h_101_50", 101, 50, 1'b0);

    wr(3, KEY_UP);
    pix("up_141_50", 141, 50, 1'b1);
    pix("left_99_50", 99, 50, 1'b0);
    pix("below_141_62", 141, 62, 1'b0);

    wr(15, KEY_H);
    pix("last_290_55", 290, 55, 1'b1);
    pix("last_291_55", 291, 55, 1'b0);
    pix("right_293_55", 293, 55, 1'b0);

    // Fill everything, clear, and keep hammering wr_en/clear while busy
    for (int i = 0; i < 16; i++) wr(i, KEY_H);
    pix("full_185_51", 185, 51, 1'b1);
    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_key  = KEY_H;
    tick();
    clear = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      clear = (cnt == 5);
      tick();
    end
    wr_en = 1'b0;
    clear = 1'b0;
    check("clear_busy_cycles", 32'(cnt), 32'd16);
    pix("clr_101_51", 101, 51, 1'b0);
    pix("clr_185_51", 185, 51, 1'b0);
    pix("clr_290_55", 290, 55, 1'b0);

    // Write and read the same slot in one cycle: first read sees the old key
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_key  = KEY_H;
    DrawX   = 10'd101;
    DrawY   = 10'd51;
    pix_valid_in = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    check("same_cycle_old", 32'(pixel_on), 32'd0);
    pix_valid_in = 1'b0;
    tick();
    check("next_cycle_new", 32'(pixel_on), 32'd1);

    // Reset on the fifth cycle of a clear, with a lit pixel in flight
    wr(15, KEY_H);
    DrawX = 10'd290;
    DrawY = 10'd55;
    pix_valid_in = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr2_busy", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    tick();
    check("pre_reset_pixel", 32'(pixel_on), 32'd1);
    Reset = 1'b1;
    pix_valid_in = 1'b0;
    tick();
    Reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pixel_on", 32'(pixel_on), 32'd0);
    check("abort_pix_valid", 32'(pix_valid_out), 32'd0);
    wr(0, KEY_H);
    pix("after_abort_101_51", 101, 51, 1'b1);
    pix("after_abort_290_55", 290, 55, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
